// File: rtl/memory_arbiter.sv
// Two-port arbiter sharing one single-port synchronous data RAM between the CPU
// and the program/debug loader; every access runs IDLE -> ISSUE -> WAIT -> ACK.
module memory_arbiter #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_ack,
    output logic [DW-1:0] c_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_ack,
    output logic [DW-1:0] l_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          owner,
    output logic          busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ACK
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_WAIT);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       grant_loader;

    // NOTE: combinational logic uses always_comb with every output assigned on
    // all paths, so no latch can be inferred.
    always_comb begin
        grant_loader = l_req && (!c_req || wait_cnt == MAX_CNT);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            c_ack    <= 1'b0;
            c_rdata  <= '0;
            l_ack    <= 1'b0;
            l_rdata  <= '0;
            m_en     <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            owner    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (c_req || l_req) begin
                        owner <= grant_loader;
                        m_en  <= 1'b1;
                        busy  <= 1'b1;
                        state <= S_ISSUE;
                        if (grant_loader) begin
                            m_we    <= l_we;
                            m_addr  <= l_addr;
                            m_wdata <= l_wdata;
                        end else begin
                            m_we    <= c_we;
                            m_addr  <= c_addr;
                            m_wdata <= c_wdata;
                        end
                    end
                    // The guard counts only arbitrations the loader actually lost.
                    if (grant_loader || !l_req) begin
                        wait_cnt <= '0;
                    end else if (wait_cnt != MAX_CNT) begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_ISSUE: begin
                    m_en  <= 1'b0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (!m_we) begin
                        if (owner) l_rdata <= m_rdata;
                        else       c_rdata <= m_rdata;
                    end
                    if (owner) l_ack <= 1'b1;
                    else       c_ack <= 1'b1;
                    state <= S_ACK;
                end
                S_ACK: begin
                    c_ack <= 1'b0;
                    l_ack <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed vector table, hand-written timing/reset
// sequences, then random traffic against a transaction-level model.
module tb_memory_arbiter;

    localparam int MAX_WAIT = 4;

    typedef struct packed {
        logic       c_req;
        logic       c_we;
        logic [7:0] c_addr;
        logic [7:0] c_wdata;
        logic       l_req;
        logic       l_we;
        logic [7:0] l_addr;
        logic [7:0] l_wdata;
    } stim_t;

    typedef struct packed {
        stim_t      s;
        logic       exp_owner;
        logic [7:0] exp_rdata;
    } vec_t;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       c_req, c_we, l_req, l_we;
    logic [7:0] c_addr, c_wdata, l_addr, l_wdata;
    logic       c_ack, l_ack, m_en, m_we, owner, busy;
    logic [7:0] c_rdata, l_rdata, m_addr, m_wdata, m_rdata;

    memory_arbiter #(.AW(8), .DW(8), .MAX_WAIT(MAX_WAIT)) dut (
        .Clk(Clk), .Rst(Rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_ack(c_ack), .c_rdata(c_rdata),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_ack(l_ack), .l_rdata(l_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .owner(owner), .busy(busy)
    );

    always #5 Clk = ~Clk;

    // Single-port synchronous RAM: read data appears the cycle after m_en.
    logic [7:0] ram [256];
    always @(posedge Clk) begin
        if (m_en) begin
            if (m_we) ram[m_addr] <= m_wdata;
            else      m_rdata     <= ram[m_addr];
        end
    end

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] ref_mem [256];
    bit         ref_valid [256];
    logic [7:0] exp_c_rdata, exp_l_rdata;
    int         losses;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic drive(input stim_t s);
        c_req = s.c_req; c_we = s.c_we; c_addr = s.c_addr; c_wdata = s.c_wdata;
        l_req = s.l_req; l_we = s.l_we; l_addr = s.l_addr; l_wdata = s.l_wdata;
    endtask

    // One full transaction from an IDLE cycle; caller supplies the winner.
    task automatic run_txn(input stim_t s, input logic exp_owner, input logic [7:0] exp_rdata);
        logic       g_we;
        logic [7:0] g_addr, g_wdata;
        g_we    = exp_owner ? s.l_we    : s.c_we;
        g_addr  = exp_owner ? s.l_addr  : s.c_addr;
        g_wdata = exp_owner ? s.l_wdata : s.c_wdata;
        drive(s);
        @(posedge Clk); #1;
        check("issue_busy", busy, 1);
        check("issue_m_en", m_en, 1);
        check("issue_owner", owner, exp_owner);
        check("issue_m_we", m_we, g_we);
        check("issue_m_addr", m_addr, g_addr);
        if (g_we) check("issue_m_wdata", m_wdata, g_wdata);
        check("issue_acks", {c_ack, l_ack}, 0);
        @(posedge Clk); #1;
        check("wait_m_en", m_en, 0);
        check("wait_m_addr_hold", m_addr, g_addr);
        check("wait_acks", {c_ack, l_ack}, 0);
        @(posedge Clk); #1;
        if (g_we) begin
            ref_mem[g_addr]   = g_wdata;
            ref_valid[g_addr] = 1'b1;
        end else if (exp_owner) begin
            exp_l_rdata = exp_rdata;
        end else begin
            exp_c_rdata = exp_rdata;
        end
        check("ack_pulse", {c_ack, l_ack}, exp_owner ? 2'b01 : 2'b10);
        check("ack_c_rdata", c_rdata, exp_c_rdata);
        check("ack_l_rdata", l_rdata, exp_l_rdata);
        check("ack_busy", busy, 1);
        if (exp_owner) l_req = 1'b0;
        else           c_req = 1'b0;
        @(posedge Clk); #1;
        check("done_acks", {c_ack, l_ack}, 0);
        check("done_busy", busy, 0);
        if (s.c_req && s.l_req)
            losses = exp_owner ? 0 : (losses < MAX_WAIT ? losses + 1 : losses);
        else
            losses = 0;
    endtask

    vec_t  vecs [7];
    int    exp_own_seq [6];
    stim_t st;
    stim_t pend;
    logic  g;
    logic [7:0] a, er;

    initial begin
        vecs[0] = '{'{1'b1, 1'b1, 8'h10, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00}, 1'b0, 8'h00};
        vecs[1] = '{'{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00}, 1'b0, 8'h3C};
        vecs[2] = '{'{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 8'hA5}, 1'b1, 8'h00};
        vecs[3] = '{'{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 8'h00}, 1'b1, 8'hA5};
        vecs[4] = '{'{1'b1, 1'b1, 8'h20, 8'h11, 1'b1, 1'b0, 8'h10, 8'h00}, 1'b0, 8'h00};
        vecs[5] = '{'{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00}, 1'b1, 8'h3C};
        vecs[6] = '{'{1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00}, 1'b0, 8'h11};
        exp_own_seq = '{0, 0, 0, 0, 1, 0};

        st = '0;
        drive(st);
        exp_c_rdata = 8'h00;
        exp_l_rdata = 8'h00;
        losses      = 0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_ctrl", {c_ack, l_ack, m_en, m_we, owner, busy}, 0);
        check("reset_rdata", {c_rdata, l_rdata}, 0);
        check("reset_mbus", {m_addr, m_wdata}, 0);
        Rst = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_txn(vecs[i].s, vecs[i].exp_owner, vecs[i].exp_rdata);
        end

        // Both requesting continuously: loader wins after MAX_WAIT losses.
        st = '0;
        drive(st);
        @(posedge Clk); #1;
        losses = 0;
        for (int i = 0; i < 6; i++) begin
            st = '{1'b1, 1'b1, 8'h40, 8'(i), 1'b1, 1'b0, 8'hFF, 8'h00};
            run_txn(st, exp_own_seq[i] != 0, 8'hA5);
            check("burst_owner_model", {31'd0, g}, {31'd0, g});
        end

        // CPU holds its request past ack: back-to-back reads every 4 cycles.
        st = '{1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00};
        drive(st);
        for (int k = 0; k < 12; k++) begin
            @(posedge Clk); #1;
            check("hold_m_en", m_en, (k % 4 == 0) ? 1 : 0);
            check("hold_c_ack", c_ack, (k % 4 == 2) ? 1 : 0);
            if (k % 4 == 2) check("hold_c_rdata", c_rdata, 8'h3C);
            if (k == 10) c_req = 1'b0;
        end
        exp_c_rdata = 8'h3C;
        losses      = 0;

        // Reset during WAIT of a CPU read, then a clean re-request.
        drive(st);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        #2 Rst = 1'b0;
        #1;
        check("midrst_ctrl", {c_ack, l_ack, m_en, m_we, owner, busy}, 0);
        check("midrst_rdata", {c_rdata, l_rdata}, 0);
        check("midrst_mbus", {m_addr, m_wdata}, 0);
        @(posedge Clk); #1;
        check("midrst_no_ack", c_ack, 0);
        #2 Rst = 1'b1;
        exp_c_rdata = 8'h00;
        exp_l_rdata = 8'h00;
        losses      = 0;
        run_txn(st, 1'b0, 8'h3C);

        // Random traffic against the transaction-level model.
        pend = '0;
        for (int slot = 0; slot < 300; slot++) begin
            if (!pend.c_req && $urandom_range(2) != 0) begin
                pend.c_req   = 1'b1;
                pend.c_addr  = 8'($urandom_range(15));
                pend.c_we    = $urandom_range(1) != 0 || !ref_valid[pend.c_addr];
                pend.c_wdata = 8'($urandom);
            end
            if (!pend.l_req && $urandom_range(2) != 0) begin
                pend.l_req   = 1'b1;
                pend.l_addr  = 8'($urandom_range(15));
                pend.l_we    = $urandom_range(1) != 0 || !ref_valid[pend.l_addr];
                pend.l_wdata = 8'($urandom);
            end
            if (!pend.c_req && !pend.l_req) begin
                drive(pend);
                @(posedge Clk); #1;
                check("idle_busy", busy, 0);
                check("idle_m_en", m_en, 0);
                losses = 0;
            end else begin
                g  = pend.l_req && (!pend.c_req || losses == MAX_WAIT);
                a  = g ? pend.l_addr : pend.c_addr;
                er = ref_mem[a];
                run_txn(pend, g, er);
                if (g) pend.l_req = 1'b0;
                else   pend.c_req = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
